multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control unit for the RISC-V-course MIPS-subset core, with LUI support. It sequences the shared datapath (single memory, single ALU, sign-extend / LUI immediate unit) through fetch, decode, execute, memory and writeback states. It holds the FSM in wait states until memory signals ready. It drives every mux select and write enable of the datapath, and decodes ALU operation from opcode/funct.

## Interface
Parameters:
- none; all encodings are fixed constants in the shared package.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- op  in  6  instruction[31:26], sampled from instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write enable
- irwrite  out  1  instruction register load
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  2  writeback: 00 = ALUOut, 01 = Data, 10 = ImmExt
- regwrite  out  1  register file write enable
- alusrca  out  1  0 = PC, 1 = A
- alusrcb  out  2  00 = B, 01 = 4, 10 = ImmExt, 11 = ImmExt<<2
- immsrc  out  1  0 = sign-extend imm16, 1 = {imm16, 16'b0}
- alucontrol  out  3  ALU op
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC write enable = pcwrite | (branch & zero)

## Operation
- Moore FSM; all outputs are combinational from state, except two fetch-phase enables:
  - irwrite is gated by mem_ready.
  - pcwrite is gated by mem_ready.
- Outputs not listed for a state are 0; alucontrol defaults to 010 (add).
- Opcode dispatch: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010, lui 001111.
- States and transitions:
  - FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. Asserts irwrite and pcwrite only when mem_ready. mem_ready → DECODE, else stay.
  - DECODE: alusrca=0, alusrcb=11, add (branch target).
    - → MEMADR for lw/sw, EXECUTE for R-type, BRANCH for beq, ADDIEX for addi, JUMP for j, LUIWB for lui.
    - Any other op → FETCH (no architectural write).
  - MEMADR: alusrca=1, alusrcb=10, add, immsrc=0. lw → MEMRD, sw → MEMWR.
  - MEMRD: iord=1. mem_ready → MEMWB, else stay.
  - MEMWB: regwrite, regdst=0, memtoreg=01 → FETCH.
  - MEMWR: iord=1, memwrite held high. mem_ready → FETCH, else stay.
  - EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct → ALUWB.
  - ALUWB: regwrite, regdst=1, memtoreg=00 → FETCH.
  - BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1 → FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, add, immsrc=0 → ADDIWB.
  - ADDIWB: regwrite, regdst=0, memtoreg=00 → FETCH.
  - JUMP: pcsrc=10, pcwrite → FETCH.
  - LUIWB: regwrite, regdst=0, memtoreg=10, immsrc=1 → FETCH.
- ALU decode:
  - aluop 00 → 010 (add); aluop 01 → 110 (sub).
  - aluop 10 uses funct:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 000
    - 100101 → 001
    - 101010 → 111
    - other funct → 010

## Timing
- Reset: while reset is high, regwrite, memwrite, irwrite and pcen are forced to 0. State becomes FETCH on the next edge.
- First edge after reset deasserts: fetch outputs are active.
- Reset mid-instruction abandons the instruction at the next edge; no partial write occurs afterward.
- Cycles per instruction with mem_ready always high:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, lui 3, illegal 2.
- Each low cycle of mem_ready in FETCH, MEMRD or MEMWR adds exactly one cycle.
- memwrite is stable for the whole MEMWR dwell.
- Simultaneous reset and mem_ready: reset wins.

## Configuration
- LUI_SUPPORT_EN defined: op 001111 dispatches to LUIWB as above.
- LUI_SUPPORT_EN undefined:
  - LUIWB state does not exist; op 001111 is treated as illegal (DECODE → FETCH).
  - immsrc is tied to 0 and memtoreg[1] is tied to 0.

## Structure
- Package mc_pkg holds:
  - the opcode and funct constants;
  - the state enum;
  - the aluop encodings (00 add, 01 sub, 10 funct);
  - the alucontrol codes.
- Sub-module aludec: combinational aluop/funct → alucontrol, instantiated once.
- FSM next-state logic and output decode live in multicycle_ctrl.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 → all write enables 0 during reset. irwrite=1 and pcen=1 on the first cycle after release.
- lw (op 100011), mem_ready=1 throughout → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 with memtoreg=01 in cycle 5.
- sw with mem_ready low for 2 cycles in MEMWR → memwrite high for 3 consecutive cycles, then FETCH.
- beq with zero=1, then zero=0 → pcen=1 with pcsrc=01 in BRANCH for the first; pcen=0 for the second.
- R-type funct 101010 → alucontrol=111 in EXECUTE, then regwrite=1 with regdst=1.
- lui (op 001111) → with LUI_SUPPORT_EN: LUIWB with immsrc=1, memtoreg=10, regwrite=1. Without it: DECODE → FETCH with no regwrite.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: opcodes, functs, FSM states, ALU codes.
// Pure constants and types, no logic.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
`ifdef LUI_SUPPORT_EN
    S_LUIWB,
`endif
    S_JUMP
  } state_t;

endpackage

// File: rtl/aludec.sv
// ALU operation decoder: aluop/funct -> alucontrol.
// Purely combinational, zero latency, no flow control.
module aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM driving all datapath selects and write enables.
// Moore outputs; FETCH, MEMRD and MEMWR stall until mem_ready. LUI path built with LUI_SUPPORT_EN.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic [1:0] memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       immsrc,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen
);

  state_t     state, state_nxt;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  always_comb begin
    state_nxt = state;
    iord      = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 2'b00;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    immsrc    = 1'b0;
    pcsrc     = 2'b00;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    aluop     = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
`ifdef LUI_SUPPORT_EN
          OP_LUI:       state_nxt = S_LUIWB;
`endif
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite  = 1'b1;
        memtoreg  = 2'b01;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite  = 1'b1;
        regdst    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc     = 2'b01;
        branch    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcwrite   = 1'b1;
        state_nxt = S_FETCH;
      end
`ifdef LUI_SUPPORT_EN
      S_LUIWB: begin
        regwrite  = 1'b1;
        memtoreg  = 2'b10;
        immsrc    = 1'b1;
        state_nxt = S_FETCH;
      end
`endif
      default: state_nxt = S_FETCH;
    endcase

    pcen = pcwrite | (branch & zero);

`ifndef LUI_SUPPORT_EN
    immsrc      = 1'b0;
    memtoreg[1] = 1'b0;
`endif

    // Architectural writes are suppressed combinationally for every reset cycle.
    if (reset) begin
      regwrite = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl; expected outputs are queued at drive time
// and checked on the falling edge by a scoreboard monitor.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       iord, memwrite, irwrite, regdst, regwrite, alusrca, immsrc, pcen;
  logic [1:0] memtoreg, alusrcb, pcsrc;
  logic [2:0] alucontrol;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .immsrc(immsrc), .alucontrol(alucontrol), .pcsrc(pcsrc),
    .pcen(pcen)
  );

  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,immsrc,alucontrol,pcsrc,pcen}
  logic [16:0] act;
  assign act = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, immsrc, alucontrol, pcsrc, pcen};

  typedef struct {
    int          id;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mr;
    logic [16:0] exp;
    logic [16:0] mask;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [16:0] FULL = 17'h1FFFF;
  localparam logic [16:0] WEN  = 17'b0_1_1_0_00_1_0_00_0_000_00_1;

  function automatic logic [16:0] ov(input logic iord_e, mw, ir, rd, input logic [1:0] mtr,
                                     input logic rw, asa, input logic [1:0] asb,
                                     input logic imm, input logic [2:0] alu,
                                     input logic [1:0] pcs, input logic pce);
    return {iord_e, mw, ir, rd, mtr, rw, asa, asb, imm, alu, pcs, pce};
  endfunction

  logic [16:0] f1, f0, dec, madr, mrd, mwb, mwr, alwb, aiex, aiwb, jmp, luiwb, br1, br0;

  task automatic add(input logic rst, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic mr, input logic [16:0] e,
                     input logic [16:0] m = FULL);
    vec_t v;
    v.id = tbl.size(); v.rst = rst; v.op = o; v.funct = f; v.zero = z; v.mr = mr;
    v.exp = e; v.mask = m;
    tbl.push_back(v);
  endtask

  function automatic logic [16:0] ex(input logic [2:0] alu);
    return ov(0,0,0,0,2'b00,0,1,2'b00,0,alu,2'b00,0);
  endfunction

  task automatic rtype(input logic [5:0] f, input logic [2:0] alu);
    add(0, 6'b000000, f, 0, 1, f1);
    add(0, 6'b000000, f, 0, 1, dec);
    add(0, 6'b000000, f, 0, 1, ex(alu));
    add(0, 6'b000000, f, 0, 1, alwb);
  endtask

  initial begin
    f1    = ov(0,0,1,0,2'b00,0,0,2'b01,0,3'b010,2'b00,1);
    f0    = ov(0,0,0,0,2'b00,0,0,2'b01,0,3'b010,2'b00,0);
    dec   = ov(0,0,0,0,2'b00,0,0,2'b11,0,3'b010,2'b00,0);
    madr  = ov(0,0,0,0,2'b00,0,1,2'b10,0,3'b010,2'b00,0);
    mrd   = ov(1,0,0,0,2'b00,0,0,2'b00,0,3'b010,2'b00,0);
    mwb   = ov(0,0,0,0,2'b01,1,0,2'b00,0,3'b010,2'b00,0);
    mwr   = ov(1,1,0,0,2'b00,0,0,2'b00,0,3'b010,2'b00,0);
    alwb  = ov(0,0,0,1,2'b00,1,0,2'b00,0,3'b010,2'b00,0);
    aiex  = ov(0,0,0,0,2'b00,0,1,2'b10,0,3'b010,2'b00,0);
    aiwb  = ov(0,0,0,0,2'b00,1,0,2'b00,0,3'b010,2'b00,0);
    jmp   = ov(0,0,0,0,2'b00,0,0,2'b00,0,3'b010,2'b10,1);
    luiwb = ov(0,0,0,0,2'b10,1,0,2'b00,1,3'b010,2'b00,0);
    br1   = ov(0,0,0,0,2'b00,0,1,2'b00,0,3'b110,2'b01,1);
    br0   = ov(0,0,0,0,2'b00,0,1,2'b00,0,3'b110,2'b01,0);

    // reset held 3 cycles with mem_ready high: no enables
    add(1, 6'b100011, 0, 0, 1, 17'd0, WEN);
    add(1, 6'b100011, 0, 0, 1, f0);
    add(1, 6'b100011, 0, 0, 1, f0);
    // lw, zero held high to expose stray pcen
    add(0, 6'b100011, 0, 1, 1, f1);
    add(0, 6'b100011, 0, 1, 1, dec);
    add(0, 6'b100011, 0, 1, 1, madr);
    add(0, 6'b100011, 0, 1, 1, mrd);
    add(0, 6'b100011, 0, 1, 1, mwb);
    // sw with two wait cycles in MEMWR
    add(0, 6'b101011, 0, 0, 1, f1);
    add(0, 6'b101011, 0, 0, 1, dec);
    add(0, 6'b101011, 0, 0, 1, madr);
    add(0, 6'b101011, 0, 0, 0, mwr);
    add(0, 6'b101011, 0, 0, 0, mwr);
    add(0, 6'b101011, 0, 0, 1, mwr);
    // fetch stall then slt
    add(0, 6'b000000, 6'b101010, 0, 0, f0);
    rtype(6'b101010, 3'b111);
    rtype(6'b100100, 3'b000);
    rtype(6'b100101, 3'b001);
    rtype(6'b100010, 3'b110);
    rtype(6'b100000, 3'b010);
    rtype(6'b000111, 3'b010);
    // beq taken / not taken
    add(0, 6'b000100, 0, 1, 1, f1);
    add(0, 6'b000100, 0, 1, 1, dec);
    add(0, 6'b000100, 0, 1, 1, br1);
    add(0, 6'b000100, 0, 0, 1, f1);
    add(0, 6'b000100, 0, 0, 1, dec);
    add(0, 6'b000100, 0, 0, 1, br0);
    // addi, j
    add(0, 6'b001000, 0, 1, 1, f1);
    add(0, 6'b001000, 0, 1, 1, dec);
    add(0, 6'b001000, 0, 1, 1, aiex);
    add(0, 6'b001000, 0, 1, 1, aiwb);
    add(0, 6'b000010, 0, 0, 1, f1);
    add(0, 6'b000010, 0, 0, 1, dec);
    add(0, 6'b000010, 0, 0, 1, jmp);
    // lui
    add(0, 6'b001111, 0, 0, 1, f1);
    add(0, 6'b001111, 0, 0, 1, dec);
`ifdef LUI_SUPPORT_EN
    add(0, 6'b001111, 0, 0, 1, luiwb);
`endif
    // illegal op
    add(0, 6'b111111, 0, 1, 1, f1);
    add(0, 6'b111111, 0, 1, 1, dec);
    // lw with a MEMRD wait
    add(0, 6'b100011, 0, 0, 1, f1);
    add(0, 6'b100011, 0, 0, 1, dec);
    add(0, 6'b100011, 0, 0, 1, madr);
    add(0, 6'b100011, 0, 0, 0, mrd);
    add(0, 6'b100011, 0, 0, 1, mrd);
    add(0, 6'b100011, 0, 0, 1, mwb);

    // hand-written: reset during ALUWB suppresses regwrite and abandons the instruction
    add(0, 6'b000000, 6'b100000, 0, 1, f1);
    add(0, 6'b000000, 6'b100000, 0, 1, dec);
    add(0, 6'b000000, 6'b100000, 0, 1, ex(3'b010));
    add(1, 6'b000000, 6'b100000, 0, 1, ov(0,0,0,1,2'b00,0,0,2'b00,0,3'b010,2'b00,0));
    add(0, 6'b000000, 6'b100000, 0, 0, f0);
    // reset in MEMWR kills memwrite
    add(0, 6'b101011, 0, 0, 1, f1);
    add(0, 6'b101011, 0, 0, 1, dec);
    add(0, 6'b101011, 0, 0, 1, madr);
    add(1, 6'b101011, 0, 0, 0, ov(1,0,0,0,2'b00,0,0,2'b00,0,3'b010,2'b00,0));
    // reset together with mem_ready in FETCH: reset wins, stays in FETCH
    add(1, 6'b000010, 0, 0, 1, f0);
    add(0, 6'b000010, 0, 0, 1, f1);
    add(0, 6'b000010, 0, 0, 1, dec);
    add(0, 6'b000010, 0, 0, 1, jmp);
`ifdef LUI_SUPPORT_EN
    add(0, 6'b001111, 0, 0, 1, f1);
`else
    add(0, 6'b001111, 0, 0, 1, f1);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      reset     = tbl[i].rst;
      op        = tbl[i].op;
      funct     = tbl[i].funct;
      zero      = tbl[i].zero;
      mem_ready = tbl[i].mr;
      sb.push_back(tbl[i]);
    end
    @(posedge clk);
    #1;
    done = 1'b1;
  end

  initial begin
    vec_t v;
    for (int c = 0; c < 5000 && !(done && sb.size() == 0); c++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        v = sb.pop_front();
        checks++;
        if ((act & v.mask) !== (v.exp & v.mask)) begin
          errors++;
          $display("FAIL vec%0d: outputs got %b want %b (mask %b)", v.id, act, v.exp, v.mask);
        end
      end
    end
    checks++;
    if (!done || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: done=%0d pending=%0d want done=1 pending=0", done, sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
